// File: rtl/fp_term_units.sv
// Three independent binary32 units for the series-iteration controller:
// integer-ness check, squarer and restoring divider, each with a request/done pulse pair.
module fp_term_units (
  input  logic        clk,
  input  logic        reset,
  input  logic        fr_ri,
  input  logic [31:0] fr_num,
  output logic        fr_res,
  output logic        fr_ro,
  input  logic        pw_ri,
  input  logic [31:0] pw_x,
  output logic [31:0] pw_res,
  output logic        pw_err,
  output logic        pw_ro,
  input  logic        dl_ri,
  input  logic [31:0] dl_x,
  input  logic [31:0] dl_n,
  output logic [31:0] dl_res,
  output logic        dl_ro
);

  // 1 when the magnitude has fractional bits; zero and denormals count as integers.
  function automatic logic frac_check(input logic [30:0] mag);
    logic [7:0]  e;
    logic [22:0] m;
    logic [22:0] mask;
    logic        r;
    e    = mag[30:23];
    m    = mag[22:0];
    mask = 23'((24'd1 << (8'd150 - e)) - 24'd1);
    if (e == 8'd0)        r = 1'b0;
    else if (e == 8'hFF)  r = 1'b1;
    else if (e >= 8'd150) r = 1'b0;
    else if (e < 8'd127)  r = 1'b1;
    else                  r = |(m & mask);
    return r;
  endfunction

  // Returns {err, result}; overflow and Inf/NaN saturate to an error with a zero result.
  function automatic logic [32:0] sq_pack(input logic zero, input logic special,
                                          input logic signed [9:0] exp, input logic [22:0] man);
    logic [32:0] r;
    if (special || exp > 10'sd254) r = {1'b1, 32'd0};
    else if (zero || exp < 10'sd1) r = 33'd0;
    else                           r = {2'b00, exp[7:0], man};
    return r;
  endfunction

  function automatic logic [31:0] dl_pack(input logic sgn, input logic xz, input logic nz,
                                          input logic signed [9:0] exp, input logic [22:0] man);
    logic [31:0] r;
    if (xz && nz)               r = 32'h7FC0_0000;
    else if (nz)                r = {sgn, 8'hFF, 23'd0};
    else if (xz)                r = {sgn, 31'd0};
    else if (exp > 10'sd254)    r = {sgn, 8'hFF, 23'd0};
    else if (exp < 10'sd1)      r = {sgn, 31'd0};
    else                        r = {sgn, exp[7:0], man};
    return r;
  endfunction

  // ---------------- fraction check ----------------
  logic        fr_vld_p0, fr_vld_p1;
  logic [30:0] fr_mag_p0;
  logic        fr_frac_p1;
  logic        fr_busy;

  assign fr_busy = fr_vld_p0 | fr_vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      fr_vld_p0 <= 1'b0;
      fr_vld_p1 <= 1'b0;
      fr_ro     <= 1'b0;
      fr_res    <= 1'b0;
    end else begin
      fr_vld_p0 <= fr_ri && !fr_busy;
      fr_vld_p1 <= fr_vld_p0;
      fr_ro     <= fr_vld_p1;
      if (fr_vld_p1) fr_res <= fr_frac_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (fr_ri && !fr_busy) fr_mag_p0 <= 31'(fr_num & 32'h7FFF_FFFF);
    // p0 -> p1: classify
    fr_frac_p1 <= frac_check(fr_mag_p0);
  end

  // ---------------- squarer ----------------
  logic              pw_vld_p0, pw_vld_p1, pw_vld_p2;
  logic [30:0]       pw_mag_p0;
  logic [24:0]       pw_prod_p1;
  logic [7:0]        pw_exp_p1;
  logic signed [9:0] pw_exp_p2;
  logic [22:0]       pw_man_p2;
  logic              pw_zero_p2, pw_inf_p2;
  logic              pw_busy;

  assign pw_busy = pw_vld_p0 | pw_vld_p1 | pw_vld_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      pw_vld_p0 <= 1'b0;
      pw_vld_p1 <= 1'b0;
      pw_vld_p2 <= 1'b0;
      pw_ro     <= 1'b0;
      pw_res    <= 32'd0;
      pw_err    <= 1'b0;
    end else begin
      pw_vld_p0 <= pw_ri && !pw_busy;
      pw_vld_p1 <= pw_vld_p0;
      pw_vld_p2 <= pw_vld_p1;
      pw_ro     <= pw_vld_p2;
      if (pw_vld_p2) {pw_err, pw_res} <= sq_pack(pw_zero_p2, pw_inf_p2, pw_exp_p2, pw_man_p2);
    end
  end

  always_ff @(posedge clk) begin
    if (pw_ri && !pw_busy) pw_mag_p0 <= 31'(pw_x & 32'h7FFF_FFFF);
    // p0 -> p1: mantissa product, kept from bit 23 up (truncation)
    pw_exp_p1  <= pw_mag_p0[30:23];
    pw_prod_p1 <= 25'(({24'd0, 1'b1, pw_mag_p0[22:0]} * {24'd0, 1'b1, pw_mag_p0[22:0]}) >> 23);
    // p1 -> p2: normalize
    pw_zero_p2 <= (pw_exp_p1 == 8'd0);
    pw_inf_p2  <= (pw_exp_p1 == 8'hFF);
    pw_exp_p2  <= $signed({1'b0, pw_exp_p1, 1'b0}) - 10'sd127 + $signed({9'd0, pw_prod_p1[24]});
    pw_man_p2  <= pw_prod_p1[24] ? pw_prod_p1[23:1] : pw_prod_p1[22:0];
  end

  // ---------------- divider ----------------
  typedef enum logic [2:0] {DL_IDLE, DL_UNPACK, DL_DIV, DL_NORM, DL_PACK} dl_state_t;

  dl_state_t         dl_state;
  logic [31:0]       dl_x_p0, dl_n_p0;
  logic              dl_sgn_p1, dl_xz_p1, dl_nz_p1;
  logic signed [9:0] dl_exp_p1;
  logic [25:0]       dl_rem_p1;
  logic [23:0]       dl_div_p1;
  logic [24:0]       dl_quo_p1;
  logic [4:0]        dl_cnt;
  logic [22:0]       dl_man_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_state <= DL_IDLE;
      dl_ro    <= 1'b0;
      dl_res   <= 32'd0;
    end else begin
      dl_ro <= 1'b0;
      case (dl_state)
        DL_IDLE: if (dl_ri) begin
          dl_x_p0  <= dl_x;
          dl_n_p0  <= dl_n;
          dl_state <= DL_UNPACK;
        end
        // p0 -> p1: unpack; the quotient of two 1.x mantissas lies in (0.5, 2)
        DL_UNPACK: begin
          dl_sgn_p1 <= dl_x_p0[31] ^ dl_n_p0[31];
          dl_xz_p1  <= (dl_x_p0[30:23] == 8'd0);
          dl_nz_p1  <= (dl_n_p0[30:23] == 8'd0);
          dl_exp_p1 <= $signed({2'b00, dl_x_p0[30:23]}) - $signed({2'b00, dl_n_p0[30:23]}) + 10'sd127;
          dl_rem_p1 <= {2'b00, 1'b1, dl_x_p0[22:0]};
          dl_div_p1 <= {1'b1, dl_n_p0[22:0]};
          dl_quo_p1 <= 25'd0;
          dl_cnt    <= 5'd0;
          dl_state  <= DL_DIV;
        end
        DL_DIV: begin
          if (dl_rem_p1 >= {2'b00, dl_div_p1}) begin
            dl_rem_p1 <= 26'((dl_rem_p1 - {2'b00, dl_div_p1}) << 1);
            dl_quo_p1 <= {dl_quo_p1[23:0], 1'b1};
          end else begin
            dl_rem_p1 <= {dl_rem_p1[24:0], 1'b0};
            dl_quo_p1 <= {dl_quo_p1[23:0], 1'b0};
          end
          dl_cnt <= dl_cnt + 5'd1;
          if (dl_cnt == 5'd24) dl_state <= DL_NORM;
        end
        // p1 -> p2: normalize quotient below 1.0
        DL_NORM: begin
          if (dl_quo_p1[24]) begin
            dl_man_p2 <= dl_quo_p1[23:1];
          end else begin
            dl_man_p2 <= dl_quo_p1[22:0];
            dl_exp_p1 <= dl_exp_p1 - 10'sd1;
          end
          dl_state <= DL_PACK;
        end
        DL_PACK: begin
          dl_res   <= dl_pack(dl_sgn_p1, dl_xz_p1, dl_nz_p1, dl_exp_p1, dl_man_p2);
          dl_ro    <= 1'b1;
          dl_state <= DL_IDLE;
        end
        default: dl_state <= DL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_term_units.sv
// Scoreboard bench for fp_term_units: drivers queue expected results from an
// integer-arithmetic float model, monitors pop and compare on each done pulse.
module tb_fp_term_units;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fr_ri = 1'b0, pw_ri = 1'b0, dl_ri = 1'b0;
  logic [31:0] fr_num = '0, pw_x = '0, dl_x = '0, dl_n = '0;
  logic        fr_res, fr_ro, pw_err, pw_ro, dl_ro;
  logic [31:0] pw_res, dl_res;

  fp_term_units dut (
    .clk(clk), .reset(reset),
    .fr_ri(fr_ri), .fr_num(fr_num), .fr_res(fr_res), .fr_ro(fr_ro),
    .pw_ri(pw_ri), .pw_x(pw_x), .pw_res(pw_res), .pw_err(pw_err), .pw_ro(pw_ro),
    .dl_ri(dl_ri), .dl_x(dl_x), .dl_n(dl_n), .dl_res(dl_res), .dl_ro(dl_ro)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          due;
  } exp_t;

  exp_t        fr_q[$], pw_q[$], dl_q[$];
  logic [31:0] dl_cur = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Value v * 2^s turned into a truncated float; returns {overflow, underflow, bits}.
  function automatic logic [33:0] mk_float(input logic sgn, input longint unsigned v, input int s);
    int k;
    int be;
    longint unsigned t;
    k = 63;
    while (k > 0 && v[k] == 1'b0) k--;
    be = k + s + 127;
    t  = v << (63 - k);
    return {be > 254, be < 1, sgn, be[7:0], t[62:40]};
  endfunction

  function automatic logic fr_model(input logic [31:0] x);
    int e;
    longint unsigned m;
    e = int'(x[30:23]);
    m = {40'd0, 1'b1, x[22:0]};
    if (e == 0) return 1'b0;
    if (e == 255) return 1'b1;
    if (e < 127) return 1'b1;
    if (e >= 150) return 1'b0;
    return (m % (64'd1 << (150 - e))) != 0;
  endfunction

  function automatic logic [32:0] pw_model(input logic [31:0] x);
    int e;
    longint unsigned m;
    logic [33:0] f;
    e = int'(x[30:23]);
    m = {40'd0, 1'b1, x[22:0]};
    if (e == 255) return {1'b1, 32'd0};
    if (e == 0) return 33'd0;
    f = mk_float(1'b0, m * m, 2 * e - 300);
    if (f[33]) return {1'b1, 32'd0};
    if (f[32]) return 33'd0;
    return {1'b0, f[31:0]};
  endfunction

  function automatic logic [31:0] dl_model(input logic [31:0] x, input logic [31:0] n);
    logic s;
    int ex, en;
    longint unsigned mx, mn;
    logic [33:0] f;
    s  = x[31] ^ n[31];
    ex = int'(x[30:23]);
    en = int'(n[30:23]);
    if (ex == 0 && en == 0) return 32'h7FC0_0000;
    if (en == 0) return {s, 8'hFF, 23'd0};
    if (ex == 0) return {s, 31'd0};
    mx = {40'd0, 1'b1, x[22:0]};
    mn = {40'd0, 1'b1, n[22:0]};
    f = mk_float(s, (mx << 30) / mn, ex - en - 30);
    if (f[33]) return {s, 8'hFF, 23'd0};
    if (f[32]) return {s, 31'd0};
    return f[31:0];
  endfunction

  // ---------------- random operands ----------------
  function automatic logic [31:0] rnd_fr();
    int k;
    logic [7:0] e;
    logic [22:0] m, mk;
    k  = $urandom_range(0, 9);
    m  = 23'($urandom);
    mk = 23'h7F_FFFF << $urandom_range(0, 23);
    if (k == 0)      begin e = 8'd0; if ($urandom_range(0, 1) == 0) m = '0; end
    else if (k == 1) e = 8'hFF;
    else if (k <= 5) begin e = 8'($urandom_range(127, 149)); m = m & mk; end
    else             e = 8'($urandom_range(110, 160));
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  function automatic logic [31:0] rnd_pw();
    int k;
    logic [7:0] e;
    k = $urandom_range(0, 9);
    if (k == 0)      e = 8'd0;
    else if (k == 1) e = 8'hFF;
    else if (k == 2) e = 8'($urandom_range(185, 196));
    else if (k == 3) e = 8'($urandom_range(58, 68));
    else             e = 8'($urandom_range(90, 165));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  function automatic logic [31:0] rnd_dl();
    int k;
    logic [7:0] e;
    k = $urandom_range(0, 9);
    if (k == 0)      e = 8'd0;
    else if (k == 1) e = 8'($urandom_range(1, 10));
    else if (k == 2) e = 8'($urandom_range(240, 254));
    else             e = 8'($urandom_range(100, 155));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // ---------------- drivers ----------------
  task automatic fr_req(input logic [31:0] v, input bit b2b);
    exp_t e;
    bit got;
    if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
    e.res = {31'd0, fr_model(v)}; e.err = 1'b0; e.due = cyc + 1 + 2;
    fr_q.push_back(e);
    fr_ri = 1'b1; fr_num = v;
    @(negedge clk);
    fr_ri = 1'b0; fr_num = $urandom;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (fr_ro) begin got = 1; break; end
      @(negedge clk);
    end
    chk("fr_done_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic pw_req(input logic [31:0] v, input bit b2b);
    exp_t e;
    bit got;
    if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
    {e.err, e.res} = pw_model(v); e.due = cyc + 1 + 3;
    pw_q.push_back(e);
    pw_ri = 1'b1; pw_x = v;
    @(negedge clk);
    pw_ri = 1'b0; pw_x = $urandom;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (pw_ro) begin got = 1; break; end
      @(negedge clk);
    end
    chk("pw_done_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic dl_req(input logic [31:0] x, input logic [31:0] n, input bit b2b);
    exp_t e;
    bit got;
    if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
    e.res = dl_model(x, n); e.err = 1'b0; e.due = cyc + 1 + 28;
    dl_q.push_back(e);
    dl_ri = 1'b1; dl_x = x; dl_n = n;
    @(negedge clk);
    dl_ri = 1'b0; dl_x = $urandom; dl_n = $urandom;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (dl_ro) begin got = 1; break; end
      @(negedge clk);
    end
    chk("dl_done_seen", {31'd0, got}, 32'd1);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_fr
    exp_t e;
    if (fr_ro === 1'b1) begin
      if (fr_q.size() == 0) chk("fr_unexpected_ro", {31'd0, fr_ro}, 32'd0);
      else begin
        e = fr_q.pop_front();
        chk("fr_res", {31'd0, fr_res}, e.res);
        chk("fr_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon_pw
    exp_t e;
    if (pw_ro === 1'b1) begin
      if (pw_q.size() == 0) chk("pw_unexpected_ro", {31'd0, pw_ro}, 32'd0);
      else begin
        e = pw_q.pop_front();
        chk("pw_res", pw_res, e.res);
        chk("pw_err", {31'd0, pw_err}, {31'd0, e.err});
        chk("pw_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon_dl
    exp_t e;
    if (rst_q) dl_cur = '0;
    if (dl_ro === 1'b1) begin
      if (dl_q.size() == 0) chk("dl_unexpected_ro", {31'd0, dl_ro}, 32'd0);
      else begin
        e = dl_q.pop_front();
        chk("dl_res", dl_res, e.res);
        chk("dl_latency", cyc, e.due);
        dl_cur = e.res;
      end
    end else if (mon_en) begin
      chk("dl_res_hold", dl_res, dl_cur);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    bit got;
    repeat (3) @(negedge clk);
    chk("rst_fr_res", {31'd0, fr_res}, 32'd0);
    chk("rst_fr_ro",  {31'd0, fr_ro},  32'd0);
    chk("rst_pw_res", pw_res, 32'd0);
    chk("rst_pw_err", {31'd0, pw_err}, 32'd0);
    chk("rst_pw_ro",  {31'd0, pw_ro},  32'd0);
    chk("rst_dl_res", dl_res, 32'd0);
    chk("rst_dl_ro",  {31'd0, dl_ro},  32'd0);
    reset  = 1'b0;
    mon_en = 1;

    fr_req(32'h4040_0000, 0);
    fr_req(32'h4020_0000, 0);
    fr_req(32'h3F00_0000, 0);
    fr_req(32'h0000_0000, 0);
    fr_req(32'h4B40_0001, 0);
    fr_req(32'h7FC0_0000, 0);
    fr_req(32'hBF80_0000, 1);

    pw_req(32'h4040_0000, 0);
    pw_req(32'hC000_0000, 0);
    pw_req(32'h7F00_0000, 0);
    pw_req(32'h4040_0000, 1);
    pw_req(32'h1F00_0000, 0);

    dl_req(32'h4110_0000, 32'h4040_0000, 0);
    dl_req(32'h3F80_0000, 32'h4080_0000, 0);
    dl_req(32'hBF80_0000, 32'h0000_0000, 0);
    dl_req(32'h0000_0000, 32'h0000_0000, 1);
    dl_req(32'h8000_0000, 32'h4040_0000, 0);

    // second request while the divider is busy must be dropped
    @(negedge clk);
    e.res = dl_model(32'h40A0_0000, 32'h4000_0000); e.err = 1'b0; e.due = cyc + 1 + 28;
    dl_q.push_back(e);
    dl_ri = 1'b1; dl_x = 32'h40A0_0000; dl_n = 32'h4000_0000;
    @(negedge clk);
    dl_ri = 1'b0;
    repeat (5) @(negedge clk);
    dl_ri = 1'b1; dl_x = 32'h4120_0000; dl_n = 32'h3F80_0000;
    @(negedge clk);
    dl_ri = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (dl_ro) begin got = 1; break; end
      @(negedge clk);
    end
    chk("dl_busy_done_seen", {31'd0, got}, 32'd1);
    repeat (40) @(negedge clk);

    // abort a divide with reset; requests coinciding with reset are dropped
    dl_ri = 1'b1; dl_x = 32'h4110_0000; dl_n = 32'h4040_0000;
    @(negedge clk);
    dl_ri = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1; fr_ri = 1'b1; fr_num = 32'h4020_0000; pw_ri = 1'b1; pw_x = 32'h4040_0000;
    @(negedge clk);
    reset = 1'b0; fr_ri = 1'b0; pw_ri = 1'b0;
    repeat (40) @(negedge clk);
    chk("dl_res_after_reset", dl_res, 32'd0);
    chk("dl_ro_after_reset", {31'd0, dl_ro}, 32'd0);
    chk("pw_res_after_reset", pw_res, 32'd0);
    dl_req(32'h4110_0000, 32'h4040_0000, 0);

    fork
      for (int i = 0; i < 60; i++) fr_req(rnd_fr(), $urandom_range(0, 3) == 0);
      for (int i = 0; i < 60; i++) pw_req(rnd_pw(), $urandom_range(0, 3) == 0);
      for (int i = 0; i < 30; i++) dl_req(rnd_dl(), rnd_dl(), $urandom_range(0, 3) == 0);
    join

    repeat (5) @(negedge clk);
    chk("fr_queue_drained", fr_q.size(), 32'd0);
    chk("pw_queue_drained", pw_q.size(), 32'd0);
    chk("dl_queue_drained", dl_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_term_units.md
# fp_term_units

Three independent single-precision (IEEE-754 binary32) arithmetic units sharing one clock and reset, each with its own one-cycle request/done handshake: an integer-ness check, a squarer, and a divider. They serve the series-iteration controller.
- The checker validates the iteration count n.
- The squarer and divider produce the two terms x·x and x/n.
- The controller sums the two terms.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all units
- fr_ri  in  1  check request pulse
- fr_num  in  32  float operand
- fr_res  out  1  1 = operand is not an integer
- fr_ro  out  1  check done pulse
- pw_ri  in  1  square request pulse
- pw_x  in  32  float operand
- pw_res  out  32  x·x
- pw_err  out  1  overflow/invalid flag
- pw_ro  out  1  square done pulse
- dl_ri  in  1  divide request pulse
- dl_x  in  32  dividend
- dl_n  in  32  divisor
- dl_res  out  32  x/n
- dl_ro  out  1  divide done pulse

## Operation

**Handshake and reset (common to all three units)**
- Each unit is idle until it samples its `*_ri` high at a clock edge.
- On that edge the unit latches its operands and becomes busy.
- `*_ri` is ignored while the unit is busy.
- The done pulse `*_ro` is high for exactly one cycle.
- `*_res` and `pw_err` become valid in the same cycle as that pulse. They hold until the next done pulse.
- `reset` takes effect as follows:
  - clears every output to 0 and aborts any operation in progress;
  - no done pulse is produced for an aborted operation;
  - a `*_ri` high in the same cycle as `reset` is ignored.
- Denormal inputs are treated as zero. Results that underflow are flushed to +0 or −0.
- Mantissa results are truncated (round toward zero).

**Fraction check (fr)**
- Let e = biased exponent and m = 1.mantissa.
- `fr_res` = 0 in these cases:
  - the operand is ±0;
  - e ≥ 150;
  - 127 ≤ e < 150 and the low (150−e) mantissa bits are all 0.
- `fr_res` = 1 in these cases:
  - the operand is nonzero with e < 127;
  - 127 ≤ e < 150 and any of the low (150−e) mantissa bits is nonzero;
  - e = 255 (Inf or NaN).
- The sign is ignored.

**Square (pw)**
- The result sign is always 0.
- Result exponent = 2e − 127, plus a normalization of +1 when the 48-bit product is ≥ 2.0.
- `pw_err` = 1 and `pw_res` = 0 when either of these holds:
  - the operand is Inf or NaN;
  - the result exponent is > 254.
- Operand ±0 gives +0 with `pw_err` = 0.
- Result exponent < 1 gives +0 with `pw_err` = 0.

**Divide (dl)**
- Implemented as restoring division of the 24-bit mantissas, one quotient bit per cycle.
- Sign = sign(x) XOR sign(n).
- Special cases:
  - n = 0 and x ≠ 0: result is signed Inf (exponent 255, mantissa 0);
  - x = 0 and n = 0: result is 0x7FC00000;
  - x = 0 and n ≠ 0: result is signed zero;
  - overflow: result is signed Inf;
  - underflow: result is signed zero.

## Timing
- Let edge E0 be the edge that samples `*_ri` high. The done pulse `*_ro` is high in the cycle following edge E0+L, where L is:
  - fr: L = 2
  - pw: L = 3
  - dl: L = 28 (1 unpack + 25 quotient iterations + 2 normalize/pack)
- `*_ro` is never high in the cycle `*_ri` is first sampled. A stale done pulse can therefore never satisfy a new request.
- Back-to-back: a new `*_ri` is accepted on the edge immediately after the `*_ro` cycle.
- The three units run fully concurrently and do not interact.

## Test plan
- **fr, integers and fractions:** `fr_num` = 0x40400000 (3.0) → `fr_res` = 0. 0x40200000 (2.5) → 1. 0x3F000000 (0.5) → 1. 0x00000000 → 0. Each `fr_ro` arrives exactly 2 cycles after the request and is 1 cycle wide.
- **pw, normal and overflow:**
  - 0x40400000 (3.0) → 0x41100000 (9.0), `pw_err` = 0.
  - 0xC0000000 (−2.0) → 0x40800000 (4.0).
  - 0x7F000000 → `pw_err` = 1, `pw_res` = 0.
  - `pw_ro` arrives exactly 3 cycles after the request.
- **dl, normal and special:**
  - x = 0x41100000 (9.0), n = 0x40400000 (3.0) → 0x40400000.
  - x = 0x3F800000 (1.0), n = 0x40800000 (4.0) → 0x3E800000.
  - x = 0xBF800000 (−1.0), n = 0 → 0xFF800000.
  - `dl_ro` arrives exactly 28 cycles after the request.
- **Reset mid-operation:** assert `reset` for 1 cycle, 10 cycles into a divide → no `dl_ro` pulse and `dl_res` = 0. A new request after reset completes normally in 28 cycles.
- **Busy and back-to-back:** pulse `dl_ri` again while busy → ignored, and only one `dl_ro` pulse occurs. Pulse `pw_ri` on the cycle after `pw_ro` → a second result arrives 3 cycles later with no stale pulse in between.
